// File: rtl/lock_seq_ctrl.sv
// Code-entry sequencer for the three-button lock: debounce, entry, check, open, lockout.
// Define LOCK_AUDIT_EN to add the fail_total lifetime failure counter port.
module lock_seq_ctrl #(
  parameter int          CLK_HZ    = 50_000_000,
  parameter int          DEB_CYC   = 1_000_000,
  parameter int          CODE_LEN  = 4,
  parameter logic [15:0] CODE      = 16'b01_10_00_01,
  parameter int          MAX_FAIL  = 3,
  parameter int          ENTRY_SEC = 9,
  parameter int          OPEN_SEC  = 5,
  parameter int          LOCK_SEC  = 9,
  parameter int          BLINK_CYC = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] btn,
  output logic       unlocked,
  output logic       alarm,
  output logic       led,
  output logic [3:0] digit,
  output logic [6:0] seg,
  output logic [2:0] fsm_state
`ifdef LOCK_AUDIT_EN
  ,
  output logic [7:0] fail_total
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_CHECK = 3'd2,
    S_OPEN  = 3'd3,
    S_LOCK  = 3'd4
  } state_e;

  localparam int TW = $clog2(CLK_HZ + 1);
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int BW = $clog2(BLINK_CYC + 1);
  localparam int IW = 4;
  localparam int CW = 2 * CODE_LEN;

  localparam logic [TW-1:0] TMAX = TW'(CLK_HZ - 1);
  localparam logic [DW-1:0] DMAX = DW'(DEB_CYC - 1);
  localparam logic [BW-1:0] BMAX = BW'(BLINK_CYC - 1);

  logic [2:0]    s1_q, s2_q, deb_q, press_q;
  logic [DW-1:0] dc_q [3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 3'b111;
      s2_q    <= 3'b111;
      deb_q   <= 3'b111;
      press_q <= 3'b000;
      for (int i = 0; i < 3; i++) dc_q[i] <= '0;
    end else begin
      s1_q <= btn;
      s2_q <= s1_q;
      for (int i = 0; i < 3; i++) begin
        press_q[i] <= 1'b0;
        if (s2_q[i] == deb_q[i]) begin
          dc_q[i] <= '0;
        end else if (dc_q[i] == DMAX) begin
          deb_q[i]   <= s2_q[i];
          dc_q[i]    <= '0;
          press_q[i] <= ~s2_q[i];
        end else begin
          dc_q[i] <= dc_q[i] + 1'b1;
        end
      end
    end
  end

  state_e        state_q, state_d;
  logic [TW-1:0] tc_q;
  logic [BW-1:0] bc_q;
  logic [3:0]    digit_q;
  logic [IW-1:0] idx_q;
  logic [CW-1:0] code_q;
  logic [3:0]    fail_cnt_q;
  logic          to_q, unl_q, alm_q, led_q;
  logic [6:0]    seg_q;

  logic       pv, enter, tick, dz, store, match, lock_hit;
  logic [1:0] sym;
  logic [3:0] inc_fail;

  // Lowest-index button wins when several presses land together.
  always_comb begin
    sym = 2'd2;
    if (press_q[1]) sym = 2'd1;
    if (press_q[0]) sym = 2'd0;
  end

  assign pv       = |press_q;
  assign dz       = (digit_q == 4'd0);
  assign match    = (code_q == CODE[CW-1:0]);
  assign inc_fail = fail_cnt_q + 4'd1;
  assign lock_hit = (inc_fail == 4'(MAX_FAIL));
  assign store    = pv && ((state_q == S_IDLE) ||
                           (state_q == S_ENTRY && !dz));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (pv) state_d = (CODE_LEN == 1) ? S_CHECK : S_ENTRY;
      S_ENTRY:
        if (dz) state_d = S_CHECK;
        else if (pv && (idx_q + 1'b1 == IW'(CODE_LEN)))
          state_d = S_CHECK;
      S_CHECK:
        if (!to_q && match) state_d = S_OPEN;
        else if (lock_hit) state_d = S_LOCK;
        else state_d = S_IDLE;
      S_OPEN:  if (dz) state_d = S_IDLE;
      S_LOCK:  if (dz) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign enter = (state_d != state_q);
  assign tick  = (tc_q == TMAX) && !enter;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tc_q       <= '0;
      bc_q       <= '0;
      digit_q    <= 4'd0;
      idx_q      <= '0;
      code_q     <= '0;
      fail_cnt_q <= 4'd0;
      to_q       <= 1'b0;
      unl_q      <= 1'b0;
      alm_q      <= 1'b0;
      led_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      to_q    <= (state_q == S_ENTRY) && dz;
      unl_q   <= (state_d == S_OPEN);
      alm_q   <= (state_d == S_LOCK);

      if (enter || tc_q == TMAX) tc_q <= '0;
      else tc_q <= tc_q + 1'b1;

      if (enter || bc_q == BMAX) bc_q <= '0;
      else bc_q <= bc_q + 1'b1;

      if (enter) begin
        case (state_d)
          S_ENTRY: digit_q <= 4'(ENTRY_SEC);
          S_OPEN:  digit_q <= 4'(OPEN_SEC);
          S_LOCK:  digit_q <= 4'(LOCK_SEC);
          default: digit_q <= 4'd0;
        endcase
      end else if (tick && !dz) begin
        digit_q <= digit_q - 4'd1;
      end

      if (enter && state_d == S_IDLE) begin
        idx_q <= '0;
      end else if (store) begin
        idx_q <= idx_q + 1'b1;
        for (int k = 0; k < CODE_LEN; k++)
          if (idx_q == IW'(k)) code_q[2*k +: 2] <= sym;
      end

      if (state_q == S_CHECK) begin
        if (!to_q && match) fail_cnt_q <= 4'd0;
        else fail_cnt_q <= inc_fail;
      end else if (state_q == S_LOCK && dz) begin
        fail_cnt_q <= 4'd0;
      end

      case (state_d)
        S_IDLE, S_ENTRY: led_q <= 1'b1;
        S_OPEN:          led_q <= 1'b0;
        S_LOCK:
          if (enter) led_q <= 1'b0;
          else if (bc_q == BMAX) led_q <= ~led_q;
        default:         led_q <= led_q;
      endcase
    end
  end

  function automatic logic [6:0] seg_dec(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seg_q <= 7'b1111111;
    else if (state_q inside {S_ENTRY, S_OPEN, S_LOCK})
      seg_q <= seg_dec(digit_q);
    else seg_q <= 7'b1111111;
  end

`ifdef LOCK_AUDIT_EN
  logic [7:0] ft_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ft_q <= 8'd0;
    else if (state_q == S_CHECK && !(!to_q && match) && ft_q != 8'hFF)
      ft_q <= ft_q + 8'd1;
  end

  assign fail_total = ft_q;
`endif

  assign unlocked  = unl_q;
  assign alarm     = alm_q;
  assign led       = led_q;
  assign digit     = digit_q;
  assign seg       = seg_q;
  assign fsm_state = state_q;

endmodule
